// File: rtl/dcache_mem_array_pkg.sv
// Shared types and sizes for the direct-mapped dcache storage array and its
// pending-miss table.
package dcache_mem_array_pkg;

  localparam int INDEX_SIZE = 4;
  localparam int TAG_SIZE   = 57;
  localparam int BLOCK_SIZE = 64;
  localparam int NUM_LINES  = 1 << INDEX_SIZE;
  localparam int TXN_W      = 4;
  localparam int NUM_TXN    = 1 << TXN_W;

  typedef logic [INDEX_SIZE-1:0] index_t;
  typedef logic [TAG_SIZE-1:0]   tag_t;
  typedef logic [BLOCK_SIZE-1:0] data_t;
  typedef logic [TXN_W-1:0]      txn_t;

  // One cache line: status bits, stored tag and the data block.
  typedef struct packed {
    logic  valid;
    logic  dirty;
    tag_t  tag;
    data_t data;
  } line_t;

  // One outstanding miss: where the returning data must land.
  typedef struct packed {
    logic   valid;
    index_t index;
    tag_t   tag;
  } pend_t;

  // A line matches a request when it holds valid data for that tag.
  function automatic logic tag_match(input line_t line, input tag_t tag);
    return line.valid && (line.tag == tag);
  endfunction

endpackage

// File: rtl/dcache_mem_array_if.sv
// Request/status bundle between the dcache controller (master) and the
// storage array (slave), including the memory response/fill signals.
interface dcache_mem_array_if import dcache_mem_array_pkg::*; ();

  index_t index_in;
  tag_t   tag_in;
  logic   read_enable;
  logic   write_enable;
  data_t  write_data_in;
  txn_t   mem_response;
  txn_t   mem_tag;
  logic   store_to_memory_enable;
  data_t  load_data_in;
  data_t  store_data_out;
  logic   data_is_valid;
  logic   data_is_dirty;
  logic   data_is_miss;
  data_t  read_data_out;

  modport master (
    output index_in, tag_in, read_enable, write_enable, write_data_in,
           mem_response, mem_tag, store_to_memory_enable, load_data_in,
    input  store_data_out, data_is_valid, data_is_dirty, data_is_miss,
           read_data_out
  );

  modport slave (
    input  index_in, tag_in, read_enable, write_enable, write_data_in,
           mem_response, mem_tag, store_to_memory_enable, load_data_in,
    output store_data_out, data_is_valid, data_is_dirty, data_is_miss,
           read_data_out
  );

endinterface

// File: rtl/dcache_mshr_table.sv
// Pending-miss table indexed by memory transaction tag. Transaction tag 0
// means "none", so entry 0 is never reported as a live lookup.
module dcache_mshr_table import dcache_mem_array_pkg::*; (
  input  logic   clock,
  input  logic   reset,
  input  logic   alloc_en,
  input  txn_t   alloc_id,
  input  index_t alloc_index,
  input  tag_t   alloc_tag,
  input  txn_t   lookup_id,
  input  logic   free_en,
  output logic   lookup_valid,
  output index_t lookup_index,
  output tag_t   lookup_tag
);

  pend_t table_q [NUM_TXN];
  pend_t table_d [NUM_TXN];

  // Lookup of the returning transaction is purely combinational.
  always_comb begin
    lookup_valid = (lookup_id != '0) && table_q[lookup_id].valid;
    lookup_index = table_q[lookup_id].index;
    lookup_tag   = table_q[lookup_id].tag;
  end

  // Free the returned entry, then record a new allocation (a re-used
  // transaction tag simply overwrites its old entry).
  always_comb begin
    table_d = table_q;
    if (free_en) begin
      table_d[lookup_id] = '0;
    end
    if (alloc_en) begin
      table_d[alloc_id] = '{valid: 1'b1, index: alloc_index, tag: alloc_tag};
    end
  end

  // Table state; reset discards every outstanding transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TXN; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/dcache_mem_array.sv
// Direct-mapped write-back dcache storage array with non-blocking miss
// tracking. Status and data outputs are combinational from the array; all
// array and pending-table updates land on the rising clock edge.
// Optional feature: define DCACHE_FILL_FORWARD_EN to let a request that
// matches a fill arriving in the same cycle see it as a hit with the fill data.
module dcache_mem_array import dcache_mem_array_pkg::*; (
  input logic               clock,
  input logic               reset,
  dcache_mem_array_if.slave bus
);

  line_t  lines_q [NUM_LINES];
  line_t  lines_d [NUM_LINES];

  line_t  cur_line;
  logic   req;
  logic   hit_arr;
  logic   fwd_hit;
  logic   hit;
  logic   miss;
  logic   fill_vld;
  index_t fill_index;
  tag_t   fill_tag;
  logic   fill_same_idx;
  logic   write_hit;

  dcache_mshr_table u_mshr (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (miss && (bus.mem_response != '0)),
    .alloc_id     (bus.mem_response),
    .alloc_index  (bus.index_in),
    .alloc_tag    (bus.tag_in),
    .lookup_id    (bus.mem_tag),
    .free_en      (fill_vld),
    .lookup_valid (fill_vld),
    .lookup_index (fill_index),
    .lookup_tag   (fill_tag)
  );

  // Hit/miss decode for the addressed line, plus optional fill forwarding.
  always_comb begin
    cur_line      = lines_q[bus.index_in];
    req           = bus.read_enable || bus.write_enable;
    hit_arr       = tag_match(cur_line, bus.tag_in);
    fill_same_idx = fill_vld && (fill_index == bus.index_in);
`ifdef DCACHE_FILL_FORWARD_EN
    fwd_hit       = fill_same_idx && (fill_tag == bus.tag_in);
`else
    fwd_hit       = 1'b0;
`endif
    hit           = hit_arr || fwd_hit;
    miss          = req && !hit;
    // A fill to the same line takes priority, so the write is dropped.
    write_hit     = bus.write_enable && hit_arr && !fill_same_idx;
  end

  // Status and data outputs for the line at index_in.
  always_comb begin
    bus.store_data_out = cur_line.data;
    bus.data_is_valid  = fwd_hit ? 1'b1 : cur_line.valid;
    bus.data_is_dirty  = fwd_hit ? 1'b0 : cur_line.dirty;
    bus.data_is_miss   = miss;
    bus.read_data_out  = '0;
    if (bus.read_enable && hit) begin
      bus.read_data_out = fwd_hit ? bus.load_data_in : cur_line.data;
    end
  end

  // Next array state: write-back clear, write hit, then fill (fill wins).
  always_comb begin
    lines_d = lines_q;
    if (bus.store_to_memory_enable) begin
      lines_d[bus.index_in].dirty = 1'b0;
    end
    if (write_hit) begin
      lines_d[bus.index_in].data  = bus.write_data_in;
      lines_d[bus.index_in].dirty = 1'b1;
    end
    if (fill_vld) begin
      lines_d[fill_index] = '{valid: 1'b1, dirty: 1'b0, tag: fill_tag,
                              data: bus.load_data_in};
    end
  end

  // Line storage; reset invalidates and zeroes every line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lines_q[i] <= '0;
      end
    end else begin
      lines_q <= lines_d;
    end
  end

endmodule

// File: tb/tb_dcache_mem_array.sv
// Bench for dcache_mem_array: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model built from plain arrays of lines and pending transactions.
module tb_dcache_mem_array;
  import dcache_mem_array_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dcache_mem_array_if bus ();

  dcache_mem_array dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state.
  logic   m_valid [16];
  logic   m_dirty [16];
  tag_t   m_tag   [16];
  data_t  m_data  [16];
  logic   p_valid [16];
  index_t p_idx   [16];
  tag_t   p_tag   [16];

  // Expected outputs for the current inputs.
  logic  e_miss, e_valid, e_dirty, e_hit_arr;
  data_t e_store, e_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0; m_dirty[k] = 1'b0; m_tag[k] = '0; m_data[k] = '0;
      p_valid[k] = 1'b0; p_idx[k] = '0; p_tag[k] = '0;
    end
  endtask

  task automatic compute_expected();
    int  i, mt;
    logic fill_ok, fwd, hit;
    i  = int'(bus.index_in);
    mt = int'(bus.mem_tag);
    fill_ok   = (mt != 0) && p_valid[mt];
    e_hit_arr = m_valid[i] && (m_tag[i] == bus.tag_in);
`ifdef DCACHE_FILL_FORWARD_EN
    fwd = fill_ok && (int'(p_idx[mt]) == i) && (p_tag[mt] == bus.tag_in);
`else
    fwd = 1'b0;
`endif
    hit     = e_hit_arr || fwd;
    e_miss  = (bus.read_enable || bus.write_enable) && !hit;
    e_valid = fwd ? 1'b1 : m_valid[i];
    e_dirty = fwd ? 1'b0 : m_dirty[i];
    e_store = m_data[i];
    e_rd    = (bus.read_enable && hit) ? (fwd ? bus.load_data_in : m_data[i]) : '0;
  endtask

  task automatic model_check();
    compute_expected();
    chk("miss",   bus.data_is_miss,   e_miss);
    chk("valid",  bus.data_is_valid,  e_valid);
    chk("dirty",  bus.data_is_dirty,  e_dirty);
    chk("store",  bus.store_data_out, e_store);
    chk("rdata",  bus.read_data_out,  e_rd);
  endtask

  // Apply this cycle's effects to the reference (called before the edge).
  task automatic model_update();
    int  i, mt, rs, fi;
    logic fill_ok;
    tag_t ft;
    compute_expected();
    i  = int'(bus.index_in);
    mt = int'(bus.mem_tag);
    rs = int'(bus.mem_response);
    fill_ok = (mt != 0) && p_valid[mt];
    fi = int'(p_idx[mt]);
    ft = p_tag[mt];
    if (!(fill_ok && fi == i)) begin
      if (bus.store_to_memory_enable) m_dirty[i] = 1'b0;
      if (bus.write_enable && e_hit_arr) begin
        m_data[i]  = bus.write_data_in;
        m_dirty[i] = 1'b1;
      end
    end
    if (fill_ok) begin
      p_valid[mt] = 1'b0;
      m_valid[fi] = 1'b1;
      m_dirty[fi] = 1'b0;
      m_tag[fi]   = ft;
      m_data[fi]  = bus.load_data_in;
    end
    if (e_miss && rs != 0) begin
      p_valid[rs] = 1'b1;
      p_idx[rs]   = bus.index_in;
      p_tag[rs]   = bus.tag_in;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    #1;
    model_check();
    if (reset) model_reset();
    else       model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drv(input int idx, input tag_t tg, input logic re, input logic we,
                     input data_t wd, input int resp, input int mt, input logic st,
                     input data_t ld);
    bus.index_in               = index_t'(idx);
    bus.tag_in                 = tg;
    bus.read_enable            = re;
    bus.write_enable           = we;
    bus.write_data_in          = wd;
    bus.mem_response           = txn_t'(resp);
    bus.mem_tag                = txn_t'(mt);
    bus.store_to_memory_enable = st;
    bus.load_data_in           = ld;
  endtask

  function automatic tag_t rtag();
    tag_t t;
    t = '0;
    t[TAG_SIZE-1] = 1'($urandom_range(0, 1));
    t[1:0]        = 2'($urandom_range(0, 3));
    return t;
  endfunction

  initial begin
    logic fwd_on;
`ifdef DCACHE_FILL_FORWARD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    model_reset();
    drv(2, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_miss",  bus.data_is_miss,   1);
    chk("rst_valid", bus.data_is_valid,  0);
    chk("rst_dirty", bus.data_is_dirty,  0);
    chk("rst_rdata", bus.read_data_out,  0);
    chk("rst_store", bus.store_data_out, 0);
    @(negedge clock);
    tick();
    reset = 1'b0;

    // First miss and fill.
    drv(2, 1, 1, 0, 0, 1, 0, 0, 0);
    #1;
    chk("m1_miss",  bus.data_is_miss,  1);
    chk("m1_valid", bus.data_is_valid, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(2, 1, 1, 0, 0, 0, 1, 0, 64'hffff);
    #1;
    chk("fill_same_cycle_miss",  bus.data_is_miss,  fwd_on ? 64'd0 : 64'd1);
    chk("fill_same_cycle_rdata", bus.read_data_out, fwd_on ? 64'hffff : 64'd0);
    tick();
    drv(2, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("m1_hit_miss",  bus.data_is_miss,  0);
    chk("m1_hit_rdata", bus.read_data_out, 64'hffff);
    tick();

    // Two misses, returned out of order.
    drv(3, 2, 1, 0, 0, 2, 0, 0, 0); tick();
    drv(4, 3, 1, 0, 0, 3, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 3, 0, 64'hbcde); tick();
    drv(0, 0, 0, 0, 0, 0, 2, 0, 64'habcd); tick();
    drv(3, 2, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ooo3_miss",  bus.data_is_miss,  0);
    chk("ooo3_rdata", bus.read_data_out, 64'habcd);
    tick();
    drv(4, 3, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ooo4_miss",  bus.data_is_miss,  0);
    chk("ooo4_rdata", bus.read_data_out, 64'hbcde);
    tick();

    // Write hit then read back.
    drv(3, 2, 0, 1, 64'hcccc, 0, 0, 0, 0);
    #1;
    chk("wr_miss", bus.data_is_miss, 0);
    tick();
    drv(3, 2, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wr_rd_miss",  bus.data_is_miss,  0);
    chk("wr_rd_dirty", bus.data_is_dirty, 1);
    chk("wr_rd_rdata", bus.read_data_out, 64'hcccc);
    tick();

    // Conflict miss exposes the dirty victim; write it back.
    drv(3, 5, 1, 0, 0, 0, 0, 1, 0);
    #1;
    chk("vic_miss",  bus.data_is_miss,   1);
    chk("vic_dirty", bus.data_is_dirty,  1);
    chk("vic_store", bus.store_data_out, 64'hcccc);
    chk("vic_rdata", bus.read_data_out,  0);
    tick();
    drv(3, 5, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wb_dirty", bus.data_is_dirty, 0);
    chk("wb_valid", bus.data_is_valid, 1);
    tick();

    // Fill and write hit to the same line in one cycle: fill wins.
    drv(4, 7, 1, 0, 0, 4, 0, 0, 0); tick();
    drv(4, 3, 0, 1, 64'h1111, 0, 4, 0, 64'h7777);
    #1;
    chk("fw_miss", bus.data_is_miss, 0);
    tick();
    drv(4, 7, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fw_miss2", bus.data_is_miss,    0);
    chk("fw_rdata", bus.read_data_out,   64'h7777);
    chk("fw_dirty", bus.data_is_dirty,   0);
    tick();
    drv(4, 3, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fw_old_miss",  bus.data_is_miss,   1);
    chk("fw_old_store", bus.store_data_out, 64'h7777);
    tick();

    // Reset mid-operation drops outstanding transaction 5.
    drv(5, 1, 1, 0, 0, 5, 0, 0, 0); tick();
    reset = 1'b1;
    drv(4, 7, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mrst_valid", bus.data_is_valid,  0);
    chk("mrst_miss",  bus.data_is_miss,   1);
    chk("mrst_rdata", bus.read_data_out,  0);
    chk("mrst_store", bus.store_data_out, 0);
    model_reset();
    tick();
    reset = 1'b0;
    drv(5, 1, 1, 0, 0, 0, 5, 0, 64'h5555);
    #1;
    chk("mrst_fill_miss", bus.data_is_miss, 1);
    tick();
    drv(5, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mrst_after_valid", bus.data_is_valid, 0);
    chk("mrst_after_miss",  bus.data_is_miss,  1);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int idx, resp, mt;
      idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      resp = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      mt   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      if (mt == resp) mt = 0;
      drv(idx, rtag(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          {$urandom, $urandom}, resp, mt,
          1'($urandom_range(0, 7) == 0), {$urandom, $urandom});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
